mips_mc_controller: RTL

- Control unit for the multicycle generation of the MIPS core.
- Replaces the single-cycle combinational controller with a Moore FSM that sequences fetch, decode, execute, memory and writeback over several cycles.
- Stalls on a memory ready handshake and traps on illegal opcodes or memory timeout.
- Sits between the instruction register (opcode/funct) and the shared multicycle datapath. Instruction-subset extensions are enabled by parameter.

---
 rtl/mips_mc_pkg.sv | 55 +++++
 rtl/mips_mc_aludec.sv | 24 ++
 rtl/mips_mc_controller.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/mips_mc_pkg.sv
// Shared constants for the multicycle MIPS controller: opcodes, funct codes,
// ALU operation codes, datapath mux selectors and the FSM state encoding.
package mips_mc_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BREX    = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JEX     = 4'd11,
    S_TRAP    = 4'd15
  } state_e;

  // States that wait on the memory handshake and are covered by the timeout.
  function automatic logic is_wait_state(input state_e s);
    return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
  endfunction

endpackage

// File: rtl/mips_mc_aludec.sv
// R-type ALU decoder: maps funct to an ALU operation and flags unsupported
// funct codes so the controller can trap on them.
module mips_mc_aludec
  import mips_mc_pkg::*;
(
  input  logic [5:0] funct,
  output logic [2:0] alucontrol,
  output logic       legal
);

  always_comb begin
    alucontrol = ALU_ADD;
    legal      = 1'b1;
    case (funct)
      FN_ADD:  alucontrol = ALU_ADD;
      FN_SUB:  alucontrol = ALU_SUB;
      FN_AND:  alucontrol = ALU_AND;
      FN_OR:   alucontrol = ALU_OR;
      FN_SLT:  alucontrol = ALU_SLT;
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/mips_mc_controller.sv
// Multicycle MIPS control unit: Moore FSM sequencing fetch/decode/execute/
// memory/writeback, with a memory-ready stall, wait timeout and sticky trap.
module mips_mc_controller
  import mips_mc_pkg::*;
#(
  parameter bit          ENABLE_BNE  = 1'b1,
  parameter bit          ENABLE_ADDI = 1'b1,
  parameter bit          ENABLE_J    = 1'b1,
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned TO_W        = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       memread,
  output logic       memwrite,
  output logic       iord,
  output logic       irwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol,
  output logic       pcen,
  output logic       trap,
  output logic [3:0] state_dbg
);

  localparam logic [TO_W-1:0] WAIT_MAX = '1;

  state_e          state_q, state_d;
  logic [TO_W-1:0] wait_q, wait_d;
  logic [2:0]      rtype_alu;
  logic            rtype_legal;
  logic            timed_out;

  mips_mc_aludec u_aludec (
    .funct      (funct),
    .alucontrol (rtype_alu),
    .legal      (rtype_legal)
  );

  // wait_q counts earlier stalled cycles, so this cycle is stall number wait_q+1.
  assign timed_out = (MEM_TIMEOUT != 0) &&
                     ((32'(wait_q) + 32'd1) >= 32'(MEM_TIMEOUT));

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:   if (mem_ready) state_d = S_DECODE;
                 else if (timed_out) state_d = S_TRAP;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_RTYPEEX;
          OP_BEQ:       state_d = S_BREX;
          OP_BNE:       state_d = ENABLE_BNE  ? S_BREX   : S_TRAP;
          OP_ADDI:      state_d = ENABLE_ADDI ? S_ADDIEX : S_TRAP;
          OP_J:         state_d = ENABLE_J    ? S_JEX    : S_TRAP;
          default:      state_d = S_TRAP;
        endcase
      end
      S_MEMADR:  state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:   if (mem_ready) state_d = S_MEMWB;
                 else if (timed_out) state_d = S_TRAP;
      S_MEMWR:   if (mem_ready) state_d = S_FETCH;
                 else if (timed_out) state_d = S_TRAP;
      S_RTYPEEX: state_d = rtype_legal ? S_RTYPEWB : S_TRAP;
      S_ADDIEX:  state_d = S_ADDIWB;
      S_MEMWB, S_RTYPEWB, S_BREX, S_ADDIWB, S_JEX: state_d = S_FETCH;
      S_TRAP:    state_d = S_TRAP;
      default:   state_d = S_TRAP;
    endcase
  end

  // Any state change clears the counter, which covers entry into a wait state.
  always_comb begin
    wait_d = '0;
    if (is_wait_state(state_q) && !mem_ready && (state_d == state_q))
      wait_d = (wait_q == WAIT_MAX) ? wait_q : wait_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    memread    = 1'b0;
    memwrite   = 1'b0;
    iord       = 1'b0;
    irwrite    = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    regwrite   = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = SRCB_REG;
    pcsrc      = PC_ALU;
    alucontrol = ALU_ADD;
    pcen       = 1'b0;
    trap       = 1'b0;
    case (state_q)
      S_FETCH: begin
        memread = 1'b1;
        alusrcb = SRCB_FOUR;
        irwrite = mem_ready;
        pcen    = mem_ready;
      end
      S_DECODE:  alusrcb = SRCB_IMM_SH;
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
      end
      S_MEMRD: begin
        memread = 1'b1;
        iord    = 1'b1;
      end
      S_MEMWB: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
      end
      S_MEMWR: begin
        memwrite = 1'b1;
        iord     = 1'b1;
      end
      S_RTYPEEX: begin
        alusrca    = 1'b1;
        alucontrol = rtype_alu;
      end
      S_RTYPEWB: begin
        regwrite = 1'b1;
        regdst   = 1'b1;
      end
      S_BREX: begin
        alusrca    = 1'b1;
        alucontrol = ALU_SUB;
        pcsrc      = PC_ALUOUT;
        pcen       = (ENABLE_BNE && (op == OP_BNE)) ? ~zero : zero;
      end
      S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
      end
      S_ADDIWB:  regwrite = 1'b1;
      S_JEX: begin
        pcsrc = PC_JUMP;
        pcen  = 1'b1;
      end
      S_TRAP:    trap = 1'b1;
      default:   ;
    endcase
    // A reset cycle must not commit any architectural write.
    if (reset) begin
      irwrite  = 1'b0;
      pcen     = 1'b0;
      regwrite = 1'b0;
      memwrite = 1'b0;
    end
  end

  assign state_dbg = state_q;

endmodule
